// File: rtl/ldl_ram_pkg.sv
// ldl_ram_pkg: shared types and helpers for the ldl_ram family.
//   rdw_mode_e   : read-during-write behaviour selector
//   RD_LAT_MAX   : deepest supported read pipeline
//   even_parity(): even-parity bit of one byte lane (lane zero-extended)
package ldl_ram_pkg;

    typedef enum logic [1:0] {
        RDW_READ_FIRST  = 2'd0,
        RDW_WRITE_FIRST = 2'd1,
        RDW_NO_CHANGE   = 2'd2
    } rdw_mode_e;

    localparam int RD_LAT_MAX   = 4;
    localparam int PAR_LANE_MAX = 64;

    function automatic logic even_parity(input logic [PAR_LANE_MAX-1:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/ldl_ram_pipe.sv
// ldl_ram_pipe: read-data delay line for stages 2..RD_LAT of the RAM.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_err/in_data   : stage input
//   out_valid/out_err/out_data: stage output after DEPTH registers
// DEPTH=0 collapses to a wire. Data registers only load on valid so the
// final stage holds the last delivered word between reads.
module ldl_ram_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_err,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             out_err,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk & rst_n;
        assign out_valid = in_valid;
        assign out_err   = in_err;
        assign out_data  = in_data;
    end else begin : g_regs
        logic [DEPTH-1:0] valid_q, valid_d;
        logic [DEPTH-1:0] err_q, err_d;
        logic [WIDTH-1:0] data_q [DEPTH];
        logic [WIDTH-1:0] data_d [DEPTH];

        always_comb begin
            data_d     = data_q;
            valid_d[0] = in_valid;
            err_d[0]   = in_err;
            if (in_valid) data_d[0] = in_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                err_d[i]   = err_q[i-1];
                if (valid_q[i-1]) data_d[i] = data_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= '0;
                err_q   <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
            end else begin
                valid_q <= valid_d;
                err_q   <= err_d;
                data_q  <= data_d;
            end
        end

        assign out_valid = valid_q[DEPTH-1];
        assign out_err   = err_q[DEPTH-1];
        assign out_data  = data_q[DEPTH-1];
    end

endmodule

// File: rtl/ldl_ram_p1_pipe.sv
// ldl_ram_p1_pipe: single-port synchronous RAM with byte-lane enables,
// RD_LAT-cycle read pipeline, selectable read-during-write behaviour and
// optional per-lane even parity (define LDL_RAM_PARITY_EN to enable).
//   clk, rst_n : clock, asynchronous active-low reset (array is not reset)
//   re, we     : read / write request, shared address addr
//   be         : per-lane write enables, din: write data
//   dout       : read data (held between reads), dvalid: new-data pulse
//   par_err    : parity mismatch on the dvalid word (0 without the macro)
module ldl_ram_p1_pipe
    import ldl_ram_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 8,
    parameter int BWIDTH   = 8,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     re,
    input  logic                     we,
    input  logic [DWIDTH/BWIDTH-1:0] be,
    input  logic [AWIDTH-1:0]        addr,
    input  logic [DWIDTH-1:0]        din,
    output logic [DWIDTH-1:0]        dout,
    output logic                     dvalid,
    output logic                     par_err
);

    localparam int unsigned NB    = DWIDTH / BWIDTH;
    localparam int unsigned DEPTH = 1 << AWIDTH;
    localparam rdw_mode_e   MODE  = rdw_mode_e'(RDW_MODE);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("ldl_ram_p1_pipe: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
    end
    if ((DWIDTH % BWIDTH) != 0 || BWIDTH > PAR_LANE_MAX) begin : g_bad_width
        $error("ldl_ram_p1_pipe: DWIDTH=%0d not a multiple of BWIDTH=%0d", DWIDTH, BWIDTH);
    end
    if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_mode
        $error("ldl_ram_p1_pipe: RDW_MODE=%0d illegal", RDW_MODE);
    end

    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (be[k]) mem_q[addr][k*BWIDTH +: BWIDTH] <= din[k*BWIDTH +: BWIDTH];
            end
        end
    end

`ifdef LDL_RAM_PARITY_EN
    logic [NB-1:0] par_mem_q [DEPTH];
    logic [NB-1:0] din_par;
    logic [NB-1:0] rd_par;

    always_comb begin
        din_par = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            din_par[k] = even_parity(PAR_LANE_MAX'(din[k*BWIDTH +: BWIDTH]));
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (be[k]) par_mem_q[addr][k] <= din_par[k];
            end
        end
    end
`endif

    logic              rd_fire;
    logic [DWIDTH-1:0] rd_word;
    logic              rd_par_err;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_err_q, s1_err_d;
    logic [DWIDTH-1:0] s1_data_q, s1_data_d;

    // Stage 1 input: array word, patched with din lanes for write-first so
    // the bypass word (and its parity) matches what the array will hold.
    always_comb begin
        rd_fire    = re && !(we && MODE == RDW_NO_CHANGE);
        rd_word    = mem_q[addr];
        rd_par_err = 1'b0;
        if (MODE == RDW_WRITE_FIRST && we) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (be[k]) rd_word[k*BWIDTH +: BWIDTH] = din[k*BWIDTH +: BWIDTH];
            end
        end
`ifdef LDL_RAM_PARITY_EN
        rd_par = par_mem_q[addr];
        if (MODE == RDW_WRITE_FIRST && we) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (be[k]) rd_par[k] = din_par[k];
            end
        end
        for (int unsigned k = 0; k < NB; k++) begin
            if (even_parity(PAR_LANE_MAX'(rd_word[k*BWIDTH +: BWIDTH])) != rd_par[k])
                rd_par_err = 1'b1;
        end
`endif
        s1_valid_d = rd_fire;
        s1_err_d   = rd_fire && rd_par_err;
        s1_data_d  = rd_fire ? rd_word : s1_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_data_q  <= s1_data_d;
        end
    end

    ldl_ram_pipe #(
        .WIDTH (DWIDTH),
        .DEPTH (RD_LAT - 1)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid_q),
        .in_err    (s1_err_q),
        .in_data   (s1_data_q),
        .out_valid (dvalid),
        .out_err   (par_err),
        .out_data  (dout)
    );

endmodule

// File: tb/tb_ldl_ram_p1_pipe.sv
// tb_ldl_ram_p1_pipe: directed bench driving three RAM instances in parallel
//   u1: RD_LAT=1 read-first, u3: RD_LAT=3 no-change, u4: RD_LAT=4 write-first
// Parity-flip steps compile only when LDL_RAM_PARITY_EN is defined.
module tb_ldl_ram_p1_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        re, we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] din;

    logic [31:0] dout1, dout3, dout4;
    logic        dv1, dv3, dv4;
    logic        pe1, pe3, pe4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ldl_ram_p1_pipe #(.DWIDTH(32), .AWIDTH(8), .BWIDTH(8), .RD_LAT(1), .RDW_MODE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .re(re), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout1), .dvalid(dv1), .par_err(pe1));
    ldl_ram_p1_pipe #(.DWIDTH(32), .AWIDTH(8), .BWIDTH(8), .RD_LAT(3), .RDW_MODE(2)) u3 (
        .clk(clk), .rst_n(rst_n), .re(re), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout3), .dvalid(dv3), .par_err(pe3));
    ldl_ram_p1_pipe #(.DWIDTH(32), .AWIDTH(8), .BWIDTH(8), .RD_LAT(4), .RDW_MODE(1)) u4 (
        .clk(clk), .rst_n(rst_n), .re(re), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout4), .dvalid(dv4), .par_err(pe4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        we = 1'b1; re = 1'b0; addr = a; din = d; be = b;
        tick();
        we = 1'b0; be = 4'h0;
    endtask

    // Issue one read (optionally with a same-edge write), then walk 4 cycles
    // checking each instance pulses dvalid only at its own latency.
    task automatic rd_exp(input logic [7:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] b, input logic [31:0] e1, input logic [31:0] e4,
                          input logic [31:0] e3, input logic v3, input logic ep);
        re = 1'b1; we = w; addr = a; din = wd; be = b;
        tick();
        re = 1'b0; we = 1'b0; be = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            chk("u1.dvalid", 32'(dv1), 32'(c == 1));
            chk("u1.dout",   dout1, e1);
            chk("u1.par_err", 32'(pe1), 32'(ep && c == 1));
            chk("u4.dvalid", 32'(dv4), 32'(c == 4));
            chk("u4.par_err", 32'(pe4), 32'(ep && c == 4));
            if (c == 4) chk("u4.dout", dout4, e4);
            chk("u3.dvalid", 32'(dv3), 32'(v3 && c == 3));
            chk("u3.par_err", 32'(pe3), 32'(v3 && ep && c == 3));
            if (c == 3) chk("u3.dout", dout3, e3);
        end
    endtask

    initial begin
        rst_n = 1'b0; re = 1'b0; we = 1'b0; be = 4'h0; addr = 8'h0; din = 32'h0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst.u1.dout", dout1, 32'h0);
        chk("rst.u3.dout", dout3, 32'h0);
        chk("rst.u4.dout", dout4, 32'h0);
        chk("rst.dvalid", {29'h0, dv1, dv3, dv4}, 32'h0);
        chk("rst.par_err", {29'h0, pe1, pe3, pe4}, 32'h0);

        // Full write then read: latency check per instance
        wr(8'd5, 32'hDEADBEEF, 4'hF);
        rd_exp(8'd5, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0);

        // Partial write, lanes 0 and 2
        wr(8'd5, 32'h11223344, 4'b0101);
        rd_exp(8'd5, 1'b0, 32'h0, 4'h0, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 1'b1, 1'b0);

        // Same-edge read+write: read-first / write-first / no-change (dout3 holds)
        wr(8'd5, 32'hAAAA5555, 4'hF);
        rd_exp(8'd5, 1'b1, 32'h12345678, 4'hF, 32'hAAAA5555, 32'h12345678, 32'hDE22BE44, 1'b0, 1'b0);
        rd_exp(8'd5, 1'b0, 32'h0, 4'h0, 32'h12345678, 32'h12345678, 32'h12345678, 1'b1, 1'b0);

        // Reset one cycle after a read: pending pulses vanish, memory survives
        re = 1'b1; addr = 8'd5;
        tick();
        re = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst.dvalid", {29'h0, dv1, dv3, dv4}, 32'h0);
        chk("midrst.dout3", dout3, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("postrst.dvalid", {29'h0, dv1, dv3, dv4}, 32'h0);
        end
        rd_exp(8'd5, 1'b0, 32'h0, 4'h0, 32'h12345678, 32'h12345678, 32'h12345678, 1'b1, 1'b0);

        // Streaming: 16 back-to-back reads of addr*3
        for (int a = 0; a < 16; a++) wr(8'(a), 32'(a * 3), 4'hF);
        for (int c = 1; c <= 19; c++) begin
            re = (c <= 16);
            addr = 8'((c - 1) % 16);
            tick();
            chk("stream.u1.dvalid", 32'(dv1), 32'(c <= 16));
            if (c <= 16) chk("stream.u1.dout", dout1, 32'((c - 1) * 3));
            chk("stream.u3.dvalid", 32'(dv3), 32'(c >= 3 && c <= 18));
            if (c >= 3 && c <= 18) chk("stream.u3.dout", dout3, 32'((c - 3) * 3));
            chk("stream.u4.dvalid", 32'(dv4), 32'(c >= 4));
            if (c >= 4) chk("stream.u4.dout", dout4, 32'((c - 4) * 3));
        end
        re = 1'b0;
        tick();

        // Clean word at addr 7
        wr(8'd7, 32'h01020304, 4'hF);
        rd_exp(8'd7, 1'b0, 32'h0, 4'h0, 32'h01020304, 32'h01020304, 32'h01020304, 1'b1, 1'b0);
`ifdef LDL_RAM_PARITY_EN
        // Flip bit 20 (lane 2) behind the parity bit's back
        u1.mem_q[7][20] = ~u1.mem_q[7][20];
        u3.mem_q[7][20] = ~u3.mem_q[7][20];
        u4.mem_q[7][20] = ~u4.mem_q[7][20];
        rd_exp(8'd7, 1'b0, 32'h0, 4'h0, 32'h01120304, 32'h01120304, 32'h01120304, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
